// File: rtl/tc_fetch_sequencer.sv
// tc_fetch_sequencer: instruction-fetch controller for the program ROM.
// Owns the PC and hides the ROM's one-cycle read latency behind valid/ready.
// Ports:
//   clk, rst (sync, active-low)
//   mem_addr / mem_b0..mem_b3 : ROM address out, registered ROM bytes in
//   instr, instr_pc, instr_valid, instr_ready : decode handshake
//   jump_en, jump_target : redirect request
//   halt, halted : halt level in, registered halt-state flag out
//   perf_fetch_cnt, perf_stall_cnt : perf counters
// Optional macro TC_FETCH_PERF_EN builds the counters; otherwise they read 0.
module tc_fetch_sequencer #(
   parameter int ADDR_W   = 8,
   parameter int STEP     = 4,
   parameter int RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_b0,
   input  logic [7:0]        mem_b1,
   input  logic [7:0]        mem_b2,
   input  logic [7:0]        mem_b3,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              jump_en,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic              halt,
   output logic              halted,
   output logic [15:0]       perf_fetch_cnt,
   output logic [15:0]       perf_stall_cnt
);

   typedef enum logic {
      S_RUN  = 1'b0,
      S_HALT = 1'b1
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_out_pc;
   logic              r_valid;
   logic              r_halted;

   logic              w_stall;
   logic              w_xfer;

   assign w_stall = r_valid && !instr_ready;
   assign w_xfer  = r_valid && instr_ready;

   // On a stall the ROM re-reads the held word so instr stays stable.
   assign mem_addr    = w_stall ? r_out_pc : r_pc;
   assign instr       = {mem_b3, mem_b2, mem_b1, mem_b0};
   assign instr_pc    = r_out_pc;
   assign instr_valid = r_valid;
   assign halted      = r_halted;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= S_RUN;
         r_pc     <= ADDR_W'(RESET_PC);
         r_out_pc <= '0;
         r_valid  <= 1'b0;
         r_halted <= 1'b0;
      end else begin
         unique case (r_state)
            S_RUN: begin
               if (halt) begin
                  // Rewind to the oldest unaccepted address for resume.
                  r_state  <= S_HALT;
                  r_halted <= 1'b1;
                  r_valid  <= 1'b0;
                  if (jump_en)
                     r_pc <= jump_target;
                  else if (w_stall)
                     r_pc <= r_out_pc;
               end else if (jump_en) begin
                  // Flush the in-flight fetch: one bubble cycle.
                  r_pc    <= jump_target;
                  r_valid <= 1'b0;
               end else if (!w_stall) begin
                  r_pc     <= r_pc + ADDR_W'(STEP);
                  r_out_pc <= r_pc;
                  r_valid  <= 1'b1;
               end
            end
            S_HALT: begin
               r_valid <= 1'b0;
               if (jump_en)
                  r_pc <= jump_target;
               if (!halt) begin
                  r_state  <= S_RUN;
                  r_halted <= 1'b0;
               end
            end
            default: begin
               r_state  <= S_RUN;
               r_halted <= 1'b0;
               r_valid  <= 1'b0;
            end
         endcase
      end
   end

`ifdef TC_FETCH_PERF_EN
   logic [15:0] r_fetch_cnt;
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_fetch_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_xfer)
            r_fetch_cnt <= r_fetch_cnt + 16'd1;
         if (w_stall)
            r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign perf_fetch_cnt = r_fetch_cnt;
   assign perf_stall_cnt = r_stall_cnt;
`else
   logic w_unused;
   assign w_unused       = w_xfer;
   assign perf_fetch_cnt = '0;
   assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_tc_fetch_sequencer.sv
// tb_tc_fetch_sequencer: directed bench for tc_fetch_sequencer.
// ROM model returns byte value == byte address, registered one cycle.
module tb_tc_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  mem_addr;
   logic [7:0]  mem_b0, mem_b1, mem_b2, mem_b3;
   logic [31:0] instr;
   logic [7:0]  instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        jump_en;
   logic [7:0]  jump_target;
   logic        halt;
   logic        halted;
   logic [15:0] perf_fetch_cnt;
   logic [15:0] perf_stall_cnt;

   int n_chk = 0;
   int n_err = 0;

   tc_fetch_sequencer #(
      .ADDR_W(8), .STEP(4), .RESET_PC(0)
   ) dut (
      .clk(clk), .rst(rst),
      .mem_addr(mem_addr),
      .mem_b0(mem_b0), .mem_b1(mem_b1),
      .mem_b2(mem_b2), .mem_b3(mem_b3),
      .instr(instr), .instr_pc(instr_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .jump_en(jump_en), .jump_target(jump_target),
      .halt(halt), .halted(halted),
      .perf_fetch_cnt(perf_fetch_cnt),
      .perf_stall_cnt(perf_stall_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      mem_b0 <= mem_addr;
      mem_b1 <= mem_addr + 8'd1;
      mem_b2 <= mem_addr + 8'd2;
      mem_b3 <= mem_addr + 8'd3;
   end

`ifdef TC_FETCH_PERF_EN
   localparam int PERF = 1;
`else
   localparam int PERF = 0;
`endif

   function automatic logic [31:0] word_at(input logic [7:0] a);
      logic [7:0] a1, a2, a3;
      a1 = a + 8'd1;
      a2 = a + 8'd2;
      a3 = a + 8'd3;
      return {a3, a2, a1, a};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_instr(input string tag, input logic [7:0] pc);
      chk({tag, ".v"}, {31'd0, instr_valid}, 32'd1);
      chk({tag, ".pc"}, {24'd0, instr_pc}, {24'd0, pc});
      chk({tag, ".ins"}, instr, word_at(pc));
   endtask

   task automatic chk_bubble(input string tag);
      chk({tag, ".v0"}, {31'd0, instr_valid}, 32'd0);
   endtask

   initial begin
      rst         = 1'b0;
      instr_ready = 1'b1;
      jump_en     = 1'b0;
      jump_target = 8'h00;
      halt        = 1'b0;
      step();
      step();
      chk("rst.valid", {31'd0, instr_valid}, 32'd0);
      chk("rst.halted", {31'd0, halted}, 32'd0);
      chk("rst.pc", {24'd0, instr_pc}, 32'd0);
      chk("rst.maddr", {24'd0, mem_addr}, 32'd0);
      chk("rst.fcnt", {16'd0, perf_fetch_cnt}, 32'd0);
      chk("rst.scnt", {16'd0, perf_stall_cnt}, 32'd0);

      rst = 1'b1;
      step();
      chk_instr("seq0", 8'h00);
      step();
      chk_instr("seq4", 8'h04);

      instr_ready = 1'b0;
      #1;
      chk("stall.maddr", {24'd0, mem_addr}, 32'h04);
      for (int i = 0; i < 3; i++) begin
         step();
         chk_instr("stall", 8'h04);
         chk("stall.maddr2", {24'd0, mem_addr}, 32'h04);
      end
      instr_ready = 1'b1;
      step();
      chk_instr("seq8", 8'h08);
      chk("perf.stall", {16'd0, perf_stall_cnt}, 32'(3 * PERF));
      chk("perf.fetch", {16'd0, perf_fetch_cnt}, 32'(2 * PERF));

      jump_en     = 1'b1;
      jump_target = 8'h31;
      step();
      jump_en = 1'b0;
      chk_bubble("jmp31");
      chk("perf.fetch2", {16'd0, perf_fetch_cnt}, 32'(3 * PERF));
      step();
      chk_instr("j31", 8'h31);
      step();
      chk_instr("j35", 8'h35);

      jump_en     = 1'b1;
      jump_target = 8'hF8;
      step();
      jump_en = 1'b0;
      chk_bubble("jmpF8");
      step();
      chk_instr("wF8", 8'hF8);
      step();
      chk_instr("wFC", 8'hFC);
      step();
      chk_instr("w00", 8'h00);

      jump_en     = 1'b1;
      jump_target = 8'h10;
      step();
      jump_en = 1'b0;
      step();
      chk_instr("h10", 8'h10);
      instr_ready = 1'b0;
      halt        = 1'b1;
      step();
      chk_bubble("halt1");
      chk("halt1.h", {31'd0, halted}, 32'd1);
      step();
      chk_bubble("halt2");
      chk("halt2.h", {31'd0, halted}, 32'd1);
      halt        = 1'b0;
      instr_ready = 1'b1;
      step();
      chk_bubble("resume0");
      chk("resume0.h", {31'd0, halted}, 32'd0);
      step();
      chk_instr("r10", 8'h10);
      step();
      chk_instr("r14", 8'h14);

      jump_en     = 1'b1;
      jump_target = 8'h20;
      step();
      jump_en = 1'b0;
      step();
      chk_instr("m20", 8'h20);
      rst = 1'b0;
      step();
      chk_bubble("mrst");
      chk("mrst.h", {31'd0, halted}, 32'd0);
      chk("mrst.fcnt", {16'd0, perf_fetch_cnt}, 32'd0);
      chk("mrst.scnt", {16'd0, perf_stall_cnt}, 32'd0);
      rst = 1'b1;
      step();
      chk_instr("a00", 8'h00);
      step();
      chk_instr("a04", 8'h04);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/tc_fetch_sequencer.md
Name: tc_fetch_sequencer

Overview:
- Instruction-fetch controller for the 8-bit-address, 4-byte-wide program ROM.
- The ROM registers its four output bytes one clock after sampling its address.
- This block owns the program counter and drives the ROM address. It hides the one-cycle read latency behind a valid/ready handshake to the decode stage, and handles jump redirects and halt/resume.
- Sits between the program ROM and the decoder in the CPU core.

Parameters:
- ADDR_W, 8: width of program counter and ROM address.
- STEP, 4: PC increment per accepted instruction, in bytes.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low. Sampled low at a rising edge, it resets all state.
- mem_addr  out  ADDR_W  ROM address (combinational from registers).
- mem_b0..mem_b3  in  8 each  ROM output bytes for the address sampled at the previous edge.
- instr  out  32  {mem_b3,mem_b2,mem_b1,mem_b0}, passed straight through.
- instr_pc  out  ADDR_W  address of the instruction on instr.
- instr_valid  out  1  instr/instr_pc hold a live instruction.
- instr_ready  in  1  decoder accepts; transfer occurs when valid&&ready at an edge.
- jump_en  in  1  redirect request, sampled at the edge.
- jump_target  in  ADDR_W  redirect address; any byte alignment is legal.
- halt  in  1  level; stop fetching while high.
- halted  out  1  registered; 1 while in the HALT state.
- perf_fetch_cnt  out  16  accepted-instruction count (see Optional Feature).
- perf_stall_cnt  out  16  backpressure-cycle count (see Optional Feature).

Behaviour:
- Internal registers:
  - pc: next address to present to the ROM.
  - out_pc: address whose data is currently on mem_b*.
  - valid_q: drives instr_valid.
  - state: RUN or HALT.
- Reset (rst==0 at an edge): pc=RESET_PC, out_pc=0, valid_q=0, state=RUN, halted=0, perf counters=0. Reset mid-operation discards any in-flight instruction.
- mem_addr:
  - out_pc when valid_q && !instr_ready (stall: ROM re-reads the same word, so instr stays stable);
  - otherwise pc.
- instr_pc = out_pc; instr_valid = valid_q.
- RUN, no jump, no halt:
  - Not stalled: pc<=pc+STEP (mod 2^ADDR_W; 0xFC -> 0x00), out_pc<=pc, valid_q<=1.
  - Stalled: pc, out_pc and valid_q hold.
- Startup latency: instr_valid=1 with instr_pc=RESET_PC in the cycle after the first edge with rst==1.
- Jump (jump_en==1 at an edge, either state):
  - pc<=jump_target, valid_q<=0 (the in-flight fetch is flushed).
  - A handshake in the same cycle still completes.
  - Result: exactly one bubble cycle; the instruction at jump_target becomes valid one edge later.
- Halt (state RUN, halt==1 at an edge):
  - state<=HALT, valid_q<=0.
  - Without a simultaneous jump: pc <= (valid_q && !instr_ready) ? out_pc : pc, so the oldest unaccepted address is refetched on resume.
  - Jump and halt at the same edge: jump_target wins for pc, and the state still goes to HALT.
- HALT:
  - instr_valid=0, halted=1, pc frozen except when jump_en loads jump_target.
  - halt==0 at an edge: state<=RUN, valid_q stays 0. Fetch restarts from pc with the normal one-cycle latency.
- halted is a registered copy of (state==HALT).

Optional Feature:
- Macro: TC_FETCH_PERF_EN.
- Defined:
  - perf_fetch_cnt increments on each accepted transfer (valid&&ready).
  - perf_stall_cnt increments each cycle with valid&&!ready.
  - Both are 16-bit, wrap 0xFFFF -> 0, and clear on reset.
- Undefined: both ports are present and tied to 0; no counter logic is built.

Test Plan:
- ROM words 0x00..0x0F; rst low 2 cycles then high, ready=1 -> instr_valid rises one cycle after the first non-reset edge. instr_pc sequence is 0x00,0x04,0x08,0x0C, and instr equals the little-endian word from each address.
- ready=0 for 3 cycles while instr_pc=0x04 -> instr and instr_pc stay at 0x04 value, mem_addr=0x04. Once ready is raised, 0x08 follows with no gap. perf_stall_cnt=3 when TC_FETCH_PERF_EN is defined, else 0.
- jump_en=1, jump_target=0x31 while instr_pc=0x08 is accepted -> one cycle with instr_valid=0, then instr_pc=0x31, then 0x35.
- Start at 0xF8 -> instr_pc sequence 0xF8,0xFC,0x00.
- halt=1 while 0x10 is valid and not accepted -> halted=1 next cycle, instr_valid=0. Release halt -> first valid instr_pc=0x10.
- rst low mid-stream at instr_pc=0x20 -> next cycle instr_valid=0, halted=0. After release, fetch restarts at RESET_PC.
